imem_fetch_buf: RTL and testbench

- Parametrised instruction memory with a multi-word fetch port, configurable read latency and an output FIFO.
- Successor to the single-word, one-cycle registered instruction store that feeds the ooocpu fetch stage.
- Supplies bundles of FETCH_WIDTH instructions per request, with a valid/ready handshake, flush on redirect and a write port for loading the image.
- Sits between the fetch PC logic and decode.

---
 rtl/imem_fetch_buf.sv | 215 +++++++++++++++++++++
 tb/tb_imem_fetch_buf.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_buf
// Description : Instruction memory with a multi-word fetch port. Each accepted
//               request reads FETCH_WIDTH consecutive 32-bit words (wrapping at
//               the top of memory), travels through a RD_LATENCY-cycle read
//               pipeline and lands in an output bundle FIFO. A credit counter
//               (in-flight + buffered) throttles requests so the FIFO never
//               overflows. flush discards everything in flight and buffered but
//               keeps a request accepted in the same cycle (the redirect
//               target). A load port writes the image, read-first against
//               same-cycle fetches.
// Optional    : IMEM_PARITY_EN - adds a stored even-parity bit per word, the
//               load_par_flip error-injection input, and per-slot insn_err.
//               Without it insn_err is tied to 0.
// Ports       : clk, rst (async, active-high)
//               rd_insn_en, pc, req_ready      - fetch request handshake
//               flush                          - redirect
//               insn, insn_pc, insn_valid,
//               insn_ready, insn_err           - bundle output handshake
//               load_en, load_addr, load_data  - image write port
//               load_par_flip                  - parity injection (optional)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_buf #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int PC_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_insn_en,
  input  logic [PC_WIDTH-1:0]            pc,
  output logic                           req_ready,
  input  logic                           flush,
  output logic [32*FETCH_WIDTH-1:0]      insn,
  output logic [PC_WIDTH-1:0]            insn_pc,
  output logic                           insn_valid,
  input  logic                           insn_ready,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
`ifdef IMEM_PARITY_EN
  input  logic                           load_par_flip,
`endif
  output logic [FETCH_WIDTH-1:0]         insn_err
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int DATA_W = 32 * FETCH_WIDTH;
  localparam int SLOT_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = SLOT_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  // --------------------------------------------------------------------------
  // Storage array (not reset) and read-first combinational bundle read
  // --------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_q [DEPTH_WORDS];

  // Stored bit is even parity of the data, optionally inverted for injection.
  always_ff @(posedge clk) begin
    if (load_en) par_q[load_addr] <= (^load_data) ^ load_par_flip;
  end
`endif

  logic [IDX_W-1:0]       rd_base;
  logic [DATA_W-1:0]      rd_data;
  logic [FETCH_WIDTH-1:0] rd_err;

  assign rd_base = pc[IDX_W+1:2];

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    // Index arithmetic is modulo 2^IDX_W, so a bundle crossing the top of
    // memory wraps to word 0 for free.
    logic [IDX_W-1:0] rd_idx;
    assign rd_idx              = rd_base + IDX_W'(k);
    assign rd_data[32*k +: 32] = mem_q[rd_idx];
`ifdef IMEM_PARITY_EN
    assign rd_err[k] = (^mem_q[rd_idx]) ^ par_q[rd_idx];
`else
    assign rd_err[k] = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Request accept and read pipeline
  // --------------------------------------------------------------------------
  logic                   accept;
  logic                   push_v;
  logic [PC_WIDTH-1:0]    push_pc;
  logic [DATA_W-1:0]      push_data;
  logic [FETCH_WIDTH-1:0] push_err;

  assign accept = rd_insn_en && req_ready;

  if (RD_LATENCY == 1) begin : g_lat1
    // Accepted request is written into the FIFO at the end of its own cycle,
    // and survives a same-cycle flush.
    assign push_v    = accept;
    assign push_pc   = pc;
    assign push_data = rd_data;
    assign push_err  = rd_err;
  end else begin : g_latn
    localparam int NST = RD_LATENCY - 1;

    logic [NST-1:0]         st_v_q;
    logic [PC_WIDTH-1:0]    st_pc_q   [NST];
    logic [DATA_W-1:0]      st_data_q [NST];
    logic [FETCH_WIDTH-1:0] st_err_q  [NST];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_v_q <= '0;
      end else begin
        // Stage 0 takes the new request even during flush; older stages die.
        st_v_q[0] <= accept;
        for (int s = 1; s < NST; s++) begin
          st_v_q[s] <= st_v_q[s-1] && !flush;
        end
      end
    end

    always_ff @(posedge clk) begin
      st_pc_q[0]   <= pc;
      st_data_q[0] <= rd_data;
      st_err_q[0]  <= rd_err;
      for (int s = 1; s < NST; s++) begin
        st_pc_q[s]   <= st_pc_q[s-1];
        st_data_q[s] <= st_data_q[s-1];
        st_err_q[s]  <= st_err_q[s-1];
      end
    end

    assign push_v    = st_v_q[NST-1] && !flush;
    assign push_pc   = st_pc_q[NST-1];
    assign push_data = st_data_q[NST-1];
    assign push_err  = st_err_q[NST-1];
  end

  // --------------------------------------------------------------------------
  // Output FIFO and credit counter
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       credit_q, credit_d;
  logic [SLOT_W-1:0]      wr_slot;
  logic [SLOT_W-1:0]      rd_slot;
  logic                   pop;
  logic                   fifo_nempty;

  logic [DATA_W-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    fifo_pc_q   [FIFO_DEPTH];
  logic [FETCH_WIDTH-1:0] fifo_err_q  [FIFO_DEPTH];

  // Pointers carry an extra wrap bit: equal pointers mean empty.
  assign fifo_nempty = (wr_ptr_q != rd_ptr_q);
  assign rd_slot     = rd_ptr_q[SLOT_W-1:0];
  assign pop         = fifo_nempty && insn_ready && !flush;
  // A surviving push during flush lands in slot 0 of the freshly reset FIFO.
  assign wr_slot     = flush ? '0 : wr_ptr_q[SLOT_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    credit_d = credit_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = push_v ? PTR_W'(1) : '0;
      credit_d = accept ? CNT_W'(1) : '0;
    end else begin
      if (push_v) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      credit_d = credit_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      credit_q <= credit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_v) begin
      fifo_data_q[wr_slot] <= push_data;
      fifo_pc_q[wr_slot]   <= push_pc;
      fifo_err_q[wr_slot]  <= push_err;
    end
  end

  // Outputs are forced to zero when the head is not valid, which gives the
  // required reset values without resetting the FIFO storage.
  assign req_ready  = (credit_q < CNT_W'(FIFO_DEPTH));
  assign insn_valid = fifo_nempty;
  assign insn       = fifo_nempty ? fifo_data_q[rd_slot] : '0;
  assign insn_pc    = fifo_nempty ? fifo_pc_q[rd_slot]   : '0;
  assign insn_err   = fifo_nempty ? fifo_err_q[rd_slot]  : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_buf
// Description : Self-checking bench for imem_fetch_buf. Two instances share
//               one stimulus stream: u_dut0 (FETCH_WIDTH=2, RD_LATENCY=1,
//               FIFO_DEPTH=4) and u_dut1 (FETCH_WIDTH=4, RD_LATENCY=3,
//               FIFO_DEPTH=8). A queue-based model tracks every accepted
//               bundle with the cycle it becomes visible; directed phases are
//               followed by randomized traffic. Define IMEM_PARITY_EN to also
//               exercise parity injection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_buf;

  logic         clk           = 1'b0;
  logic         rst           = 1'b1;
  logic         rd_insn_en    = 1'b0;
  logic [31:0]  pc            = '0;
  logic         flush         = 1'b0;
  logic         insn_ready    = 1'b0;
  logic         load_en       = 1'b0;
  logic [9:0]   load_addr     = '0;
  logic [31:0]  load_data     = '0;
  logic         load_par_flip = 1'b0;

  logic         r0, v0, r1, v1;
  logic [63:0]  insn0;
  logic [127:0] insn1;
  logic [31:0]  ipc0, ipc1;
  logic [1:0]   err0;
  logic [3:0]   err1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_fetch_buf #(
    .FETCH_WIDTH(2), .DEPTH_WORDS(1024), .RD_LATENCY(1), .FIFO_DEPTH(4), .PC_WIDTH(32)
  ) u_dut0 (
    .clk(clk), .rst(rst), .rd_insn_en(rd_insn_en), .pc(pc), .req_ready(r0),
    .flush(flush), .insn(insn0), .insn_pc(ipc0), .insn_valid(v0),
    .insn_ready(insn_ready), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip(load_par_flip),
`endif
    .insn_err(err0)
  );

  imem_fetch_buf #(
    .FETCH_WIDTH(4), .DEPTH_WORDS(1024), .RD_LATENCY(3), .FIFO_DEPTH(8), .PC_WIDTH(32)
  ) u_dut1 (
    .clk(clk), .rst(rst), .rd_insn_en(rd_insn_en), .pc(pc), .req_ready(r1),
    .flush(flush), .insn(insn1), .insn_pc(ipc1), .insn_valid(v1),
    .insn_ready(insn_ready), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip(load_par_flip),
`endif
    .insn_err(err1)
  );

  task automatic chk(input string nm, input int inst, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got %h, expected %h", nm, inst, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: every accepted bundle is an entry carrying the cycle
  // at which it becomes visible at the head; credits = entries of that DUT.
  // --------------------------------------------------------------------------
  typedef struct {
    int           inst;
    logic [31:0]  pc;
    logic [127:0] data;
    logic [3:0]   err;
    int           vis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mem_m  [1024];
  logic        flip_m [1024];
  int          cyc = 0;

  function automatic int lat(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int fw (input int i); return (i == 0) ? 2 : 4; endfunction
  function automatic int fd (input int i); return (i == 0) ? 4 : 8; endfunction

  function automatic int mcount(input int i);
    int n = 0;
    for (int j = 0; j < mq.size(); j++) if (mq[j].inst == i) n++;
    return n;
  endfunction

  function automatic int mhead(input int i);
    for (int j = 0; j < mq.size(); j++) if (mq[j].inst == i) return j;
    return -1;
  endfunction

  task automatic mdrop(input int i);
    for (int j = mq.size() - 1; j >= 0; j--) if (mq[j].inst == i) mq.delete(j);
  endtask

  int           h;
  logic         ev, er;
  logic [127:0] ed;
  logic [31:0]  ep;
  logic [3:0]   ee;
  logic [31:0]  wsum;
  ent_t         e;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) mdrop(i);
      h  = mhead(i);
      ev = 1'b0; ed = '0; ep = '0; ee = '0;
      if (h >= 0) begin
        if (mq[h].vis <= cyc) begin
          ev = 1'b1; ed = mq[h].data; ep = mq[h].pc; ee = mq[h].err;
        end
      end
      er = (mcount(i) < fd(i));
      chk("req_ready",  i, 128'(i == 0 ? r0 : r1), 128'(er));
      chk("insn_valid", i, 128'(i == 0 ? v0 : v1), 128'(ev));
      chk("insn",       i, (i == 0) ? {64'h0, insn0} : insn1, ed);
      chk("insn_pc",    i, 128'(i == 0 ? ipc0 : ipc1), 128'(ep));
      chk("insn_err",   i, 128'(i == 0 ? {2'b00, err0} : err1), 128'(ee));
      if (!rst) begin
        if (flush) mdrop(i);
        else if (ev && insn_ready) mq.delete(h);
        if (rd_insn_en && er) begin
          e.inst = i; e.pc = pc; e.data = '0; e.err = '0; e.vis = cyc + lat(i);
          for (int k = 0; k < fw(i); k++) begin
            wsum = (pc >> 2) + 32'(k);
            e.data[32*k +: 32] = mem_m[wsum[9:0]];
`ifdef IMEM_PARITY_EN
            e.err[k] = flip_m[wsum[9:0]];
`endif
          end
          mq.push_back(e);
        end
      end
    end
    // Loads are applied after the reads of this cycle (read-first).
    if (load_en) begin
      mem_m[load_addr]  = load_data;
      flip_m[load_addr] = load_par_flip;
    end
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Stimulus with hand-computed pins. Inputs change 1 time unit after posedge.
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_insn_en = 1'b0; insn_ready = 1'b1;
    repeat (n) tick();
  endtask

  int nacc0, nacc1;

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Preload every word with 0x13 + index.
    for (int a = 0; a < 1024; a++) begin
      load_en = 1'b1; load_addr = a[9:0]; load_data = 32'h13 + 32'(a);
      tick();
    end
    load_en = 1'b0;

    // Basic streaming fetch.
    insn_ready = 1'b1; rd_insn_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      pc = 32'(8 * c);
      @(negedge clk);
      if (c == 1) begin
        chk("basic_b0_data", 0, 128'(insn0), 128'(64'h00000014_00000013));
        chk("basic_b0_pc",   0, 128'(ipc0),  128'(0));
      end
      if (c == 2) chk("basic_b1_pc", 0, 128'(ipc0), 128'(32'h8));
      if (c == 3) chk("basic_b0_data4", 1, insn1,
                      128'h00000016_00000015_00000014_00000013);
      tick();
    end
    idle(6);

    // Backpressure: count accepts with the consumer stalled.
    insn_ready = 1'b0; rd_insn_en = 1'b1; nacc0 = 0; nacc1 = 0;
    for (int c = 0; c < 10; c++) begin
      pc = 32'(8 * c);
      @(negedge clk);
      if (r0) nacc0++;
      if (r1) nacc1++;
      tick();
    end
    rd_insn_en = 1'b0; insn_ready = 1'b1;
    chk("bp_accepts", 0, 128'(nacc0), 128'(4));
    chk("bp_accepts", 1, 128'(nacc1), 128'(8));
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      if (d == 0) chk("bp_ready_low", 0, 128'(r0), 128'(0));
      chk("bp_drain_pc", 0, 128'(ipc0), 128'(32'(8 * d)));
      tick();
    end
    idle(10);

    // Wrap at the top of memory.
    rd_insn_en = 1'b1; pc = 32'hFFC;
    tick();
    rd_insn_en = 1'b0;
    @(negedge clk);
    chk("wrap", 0, 128'(insn0), 128'({32'h13, 32'h412}));
    idle(6);

    // Read-first collision on word 4.
    load_en = 1'b1; load_addr = 10'd4; load_data = 32'hDEADBEEF;
    rd_insn_en = 1'b1; pc = 32'h10;
    tick();
    load_en = 1'b0; rd_insn_en = 1'b0;
    @(negedge clk);
    chk("rf_old", 0, 128'(insn0[31:0]), 128'(32'h17));
    tick();
    rd_insn_en = 1'b1; pc = 32'h10;
    tick();
    rd_insn_en = 1'b0;
    @(negedge clk);
    chk("rf_new", 0, 128'(insn0[31:0]), 128'(32'hDEADBEEF));
    idle(6);

    // Flush with two bundles buffered and two in flight in dut1.
    insn_ready = 1'b0; rd_insn_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      pc = 32'(8 * c);
      tick();
    end
    flush = 1'b1; pc = 32'h100;
    tick();
    flush = 1'b0; rd_insn_en = 1'b0;
    @(negedge clk);
    chk("flush_stale", 1, 128'(v1), 128'(0));
    chk("flush_stale", 0, 128'(v0), 128'(0));
    tick();
    @(negedge clk);
    chk("flush_stale2", 1, 128'(v1), 128'(0));
    tick();
    @(negedge clk);
    chk("flush_target_v",  1, 128'(v1),   128'(1));
    chk("flush_target_pc", 1, 128'(ipc1), 128'(32'h100));
    idle(6);

`ifdef IMEM_PARITY_EN
    // Parity injection on word 2, cleared by flush and by reset.
    load_en = 1'b1; load_addr = 10'd2; load_data = 32'h15; load_par_flip = 1'b1;
    tick();
    load_en = 1'b0; load_par_flip = 1'b0;
    insn_ready = 1'b0; rd_insn_en = 1'b1; pc = 32'h0;
    tick();
    rd_insn_en = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("par_err", 1, 128'(err1), 128'(4'b0100));
    chk("par_err", 0, 128'(err0), 128'(2'b00));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("par_flush", 1, 128'(err1), 128'(0));
    rd_insn_en = 1'b1;
    tick();
    rd_insn_en = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("par_err2", 1, 128'(err1), 128'(4'b0100));
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("par_reset", 1, 128'(err1), 128'(0));
    tick();
    rst = 1'b0;
    load_en = 1'b1; load_addr = 10'd2; load_data = 32'h15;
    tick();
    load_en = 1'b0;
    idle(4);
`endif

    // Reset asserted mid-stream.
    insn_ready = 1'b1; rd_insn_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      pc = 32'(16 * c);
      tick();
    end
    rst = 1'b1; rd_insn_en = 1'b0;
    @(negedge clk);
    chk("rst_ready", 1, 128'(r1), 128'(1));
    chk("rst_valid", 0, 128'(v0), 128'(0));
    tick();
    rst = 1'b0;
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst        = (n == 300) || (n == 301);
      rd_insn_en = ($urandom_range(3) != 0);
      pc         = $urandom & 32'hFFFF_FFFC;
      insn_ready = ($urandom_range(3) != 0);
      flush      = ($urandom_range(19) == 0);
      load_en    = ($urandom_range(4) == 0) && !rst;
      load_addr  = 10'($urandom);
      load_data  = $urandom;
`ifdef IMEM_PARITY_EN
      load_par_flip = ($urandom_range(7) == 0);
`endif
      tick();
    end
    rst = 1'b0; flush = 1'b0; load_en = 1'b0;
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
